ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- clk_i in 1: single clock; all state updates on rising edge.
- rst_i in 1: reset, synchronous, active-high.
- mem_stall_i in 1: memory-side stall; EX/MEM outputs hold.
- MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i in 1 each: control fields from ID/EX.
- ALUOp_i in 2: control field from ID/EX.
- funct_i in 10: {funct7, funct3} from ID/EX.
- RS1data_i, RS2data_i, imm_i in 32 each: operands from ID/EX.
- RDaddr_i, RS1addr_i, RS2addr_i in 5 each: register addresses from ID/EX.
- WBRegWrite_i in 1, WBRDaddr_i in 5, WBdata_i in 32: writeback-stage forwarding source.
- MemRead_o, MemtoReg_o, MemWrite_o, RegWrite_o out 1 each: registered EX/MEM controls.
- ALUresult_o out 32: registered EX/MEM result.
- RS2data_o out 32: registered forwarded store data.
- RDaddr_o out 5: registered destination address.
- stall_o out 1: hold request to IF/ID and ID/EX.

Function
REQ-002 Forwarding, operand A (same rule for B with RS2addr_i): the EX/MEM register is the source when RegWrite_o=1, RDaddr_o!=0 and RDaddr_o==RS1addr_i. Otherwise WB is the source when WBRegWrite_i=1, WBRDaddr_i!=0 and address matches. Otherwise RS1data_i is used. EX/MEM has priority over WB.
REQ-003 Forwarded value of the EX/MEM source SHALL be ALUresult_o; a load in EX/MEM is not forwarded (the hazard unit guarantees a bubble).
REQ-004 Operand B SHALL be imm_i when ALUSrc_i=1, else forwarded RS2; store data SHALL always be forwarded RS2.
REQ-005 ALUOp_i=00: A+B; ALUOp_i=01: A-B.
REQ-006 ALUOp_i=10 (R-type) funct_i map: 0000000_000 add; 0100000_000 sub; 0000000_111 and; 0000000_110 or; 0000000_100 xor; 0000000_001 sll by B[4:0]; 0100000_101 sra by B[4:0]; 0000001_000 mul. Any other code -> result 0.
REQ-007 ALUOp_i=11 (I-arith): funct3 000 addi; funct3 101 srai by imm_i[4:0]; others -> 0.
REQ-008 All arithmetic SHALL be 32-bit modulo; mul returns low 32 bits of the unsigned shift-add product, which equals the signed low word.
REQ-009 Non-mul latency SHALL be one cycle: outputs load at the next edge when mem_stall_i=0.
REQ-010 MUL FSM states SHALL be IDLE, BUSY and DONE, with a 5-bit iteration counter.
REQ-011 IDLE with mul decoded and mem_stall_i=0: stall_o=1. At the edge, forwarded A and B are latched into the multiplicand and multiplier, the accumulator is cleared, count=0, the state goes to BUSY, and EX/MEM loads a bubble.
REQ-012 BUSY: stall_o=1. Each edge performs one iteration (add the multiplicand if multiplier[0]=1, shift the multiplicand left, shift the multiplier right) and increments count. The edge with count==31 goes to DONE. EX/MEM loads a bubble each edge unless mem_stall_i=1.
REQ-013 BUSY SHALL keep iterating regardless of mem_stall_i.
REQ-014 DONE: stall_o=0. At the first edge with mem_stall_i=0, EX/MEM loads the product with the latched mul controls and RDaddr, and the state goes to IDLE. With mem_stall_i=1, DONE holds.
REQ-015 A mul SHALL occupy EX for exactly 34 cycles when unstalled: 1 IDLE + 32 BUSY + 1 DONE.
REQ-016 Bubble SHALL be all EX/MEM outputs zero.
REQ-017 mem_stall_i=1 in IDLE: outputs hold, no mul start, stall_o=0.
REQ-018 stall_o SHALL be combinational from state and decode.

Reset
REQ-019 rst_i=1 at an edge SHALL zero all outputs, set the state to IDLE, and clear the counter and datapath registers. stall_o SHALL be 0 while rst_i=1.
REQ-020 Reset mid-multiply SHALL discard the operation; no result is written.
REQ-021 Reset SHALL take priority over mem_stall_i.

Verification
REQ-022 add, RS1data_i=5, RS2data_i=7, RDaddr_i=3, RegWrite_i=1, no forwarding -> next cycle ALUresult_o=12, RDaddr_o=3, RegWrite_o=1.
REQ-023 Back-to-back: add x1=2+3, then sub x2=x1-1 with RS1data_i stale=0 -> second ALUresult_o=4 via EX/MEM forward. With WB also matching x1 at 9, EX/MEM still wins.
REQ-024 mul, A=0xFFFFFFFF, B=3 -> stall_o high 33 cycles, ALUresult_o=0xFFFFFFFD written on the 34th edge, bubbles (RegWrite_o=0) before it.
REQ-025 mul, A=6, B=7, with mem_stall_i=1 asserted during BUSY and held 3 cycles into DONE -> DONE holds, outputs unchanged, result 42 loads on the first edge after release.
REQ-026 rst_i pulsed at BUSY count=10 -> all outputs 0, stall_o=0, state IDLE, no product ever appears.
REQ-027 Forward to x0: RDaddr_o=0, RegWrite_o=1, RS1addr_i=0, RS1data_i=0 -> operand 0 is used, not ALUresult_o.

Source files
------------

// File: rtl/ex_stage.sv
// EX stage: operand forwarding, single-cycle ALU and an iterative
// shift-add multiplier that holds the front end while it runs.
module ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_stall_i,
  input  logic        MemRead_i,
  input  logic        MemtoReg_i,
  input  logic        MemWrite_i,
  input  logic        ALUSrc_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [9:0]  funct_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic        WBRegWrite_i,
  input  logic [4:0]  WBRDaddr_i,
  input  logic [31:0] WBdata_i,
  output logic        MemRead_o,
  output logic        MemtoReg_o,
  output logic        MemWrite_o,
  output logic        RegWrite_o,
  output logic [31:0] ALUresult_o,
  output logic [31:0] RS2data_o,
  output logic [4:0]  RDaddr_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [9:0] F_ADD = 10'b0000000_000;
  localparam logic [9:0] F_SUB = 10'b0100000_000;
  localparam logic [9:0] F_AND = 10'b0000000_111;
  localparam logic [9:0] F_OR  = 10'b0000000_110;
  localparam logic [9:0] F_XOR = 10'b0000000_100;
  localparam logic [9:0] F_SLL = 10'b0000000_001;
  localparam logic [9:0] F_SRA = 10'b0100000_101;
  localparam logic [9:0] F_MUL = 10'b0000001_000;

  state_e      state_q;
  state_e      state_d;
  logic [31:0] mcand_q;
  logic [31:0] mcand_d;
  logic [31:0] mplier_q;
  logic [31:0] mplier_d;
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [4:0]  cnt_q;
  logic [4:0]  cnt_d;

  // Controls captured at multiply start, replayed when the product retires.
  logic [3:0]  mctl_q;
  logic [3:0]  mctl_d;
  logic [4:0]  mrd_q;
  logic [4:0]  mrd_d;
  logic [31:0] mrs2_q;
  logic [31:0] mrs2_d;

  // EX/MEM register; ctl = {MemRead, MemtoReg, MemWrite, RegWrite}.
  logic [3:0]  ctl_q;
  logic [3:0]  ctl_d;
  logic [31:0] alu_q;
  logic [31:0] alu_d;
  logic [31:0] rs2_q;
  logic [31:0] rs2_d;
  logic [4:0]  rd_q;
  logic [4:0]  rd_d;

  logic        fa_mem;
  logic        fa_wb;
  logic        fb_mem;
  logic        fb_wb;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [3:0]  ctl_in;
  logic        is_mul;

  logic r_add;
  logic r_sub;
  logic r_and;
  logic r_or;
  logic r_xor;
  logic r_sll;
  logic r_sra;

  assign fa_mem = ctl_q[0]
               && (rd_q != 5'd0)
               && (rd_q == RS1addr_i);
  assign fa_wb  = WBRegWrite_i
               && (WBRDaddr_i != 5'd0)
               && (WBRDaddr_i == RS1addr_i);
  assign fb_mem = ctl_q[0]
               && (rd_q != 5'd0)
               && (rd_q == RS2addr_i);
  assign fb_wb  = WBRegWrite_i
               && (WBRDaddr_i != 5'd0)
               && (WBRDaddr_i == RS2addr_i);

  assign fwd_a = fa_mem ? alu_q
               : fa_wb  ? WBdata_i
               : RS1data_i;
  assign fwd_b = fb_mem ? alu_q
               : fb_wb  ? WBdata_i
               : RS2data_i;

  assign op_b = ALUSrc_i ? imm_i : fwd_b;

  assign ctl_in = {MemRead_i, MemtoReg_i,
                   MemWrite_i, RegWrite_i};

  assign is_mul = (ALUOp_i == 2'b10)
               && (funct_i == F_MUL);

  assign r_add = (funct_i == F_ADD);
  assign r_sub = (funct_i == F_SUB);
  assign r_and = (funct_i == F_AND);
  assign r_or  = (funct_i == F_OR);
  assign r_xor = (funct_i == F_XOR);
  assign r_sll = (funct_i == F_SLL);
  assign r_sra = (funct_i == F_SRA);

  always_comb begin
    alu_res = '0;
    case (ALUOp_i)
      2'b00: alu_res = fwd_a + op_b;
      2'b01: alu_res = fwd_a - op_b;
      2'b10: begin
        unique case (1'b1)
          r_add: alu_res = fwd_a + op_b;
          r_sub: alu_res = fwd_a - op_b;
          r_and: alu_res = fwd_a & op_b;
          r_or:  alu_res = fwd_a | op_b;
          r_xor: alu_res = fwd_a ^ op_b;
          r_sll: alu_res = fwd_a << op_b[4:0];
          r_sra: alu_res = $signed(fwd_a)
                           >>> op_b[4:0];
          default: alu_res = '0;
        endcase
      end
      2'b11: begin
        case (funct_i[2:0])
          3'b000: alu_res = fwd_a + op_b;
          3'b101: alu_res = $signed(fwd_a)
                            >>> imm_i[4:0];
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mctl_d   = mctl_q;
    mrd_d    = mrd_q;
    mrs2_d   = mrs2_q;
    ctl_d    = ctl_q;
    alu_d    = alu_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    case (state_q)
      IDLE: begin
        if (!mem_stall_i) begin
          if (is_mul) begin
            mcand_d  = fwd_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
            mctl_d   = ctl_in;
            mrd_d    = RDaddr_i;
            mrs2_d   = fwd_b;
            state_d  = BUSY;
            ctl_d    = '0;
            alu_d    = '0;
            rs2_d    = '0;
            rd_d     = '0;
          end else begin
            ctl_d = ctl_in;
            alu_d = alu_res;
            rs2_d = fwd_b;
            rd_d  = RDaddr_i;
          end
        end
      end
      BUSY: begin
        // Iterates even under a memory stall; only EX/MEM holds.
        acc_d = acc_q
              + (mplier_q[0] ? mcand_q : 32'd0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end
        if (!mem_stall_i) begin
          ctl_d = '0;
          alu_d = '0;
          rs2_d = '0;
          rd_d  = '0;
        end
      end
      DONE: begin
        if (!mem_stall_i) begin
          ctl_d   = mctl_q;
          alu_d   = acc_q;
          rs2_d   = mrs2_q;
          rd_d    = mrd_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mctl_q   <= '0;
      mrd_q    <= '0;
      mrs2_q   <= '0;
      ctl_q    <= '0;
      alu_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mctl_q   <= mctl_d;
      mrd_q    <= mrd_d;
      mrs2_q   <= mrs2_d;
      ctl_q    <= ctl_d;
      alu_q    <= alu_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
    end
  end

  assign stall_o = !rst_i
                && ((state_q == BUSY)
                 || ((state_q == IDLE)
                  && is_mul
                  && !mem_stall_i));

  assign MemRead_o   = ctl_q[3];
  assign MemtoReg_o  = ctl_q[2];
  assign MemWrite_o  = ctl_q[1];
  assign RegWrite_o  = ctl_q[0];
  assign ALUresult_o = alu_q;
  assign RS2data_o   = rs2_q;
  assign RDaddr_o    = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed forwarding, multiply and
// reset cases followed by randomized instruction streams.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_stall;
  logic        MemRead, MemtoReg, MemWrite;
  logic        ALUSrc, RegWrite;
  logic [1:0]  ALUOp;
  logic [9:0]  funct;
  logic [31:0] RS1data, RS2data, imm;
  logic [4:0]  RDaddr, RS1addr, RS2addr;
  logic        WBRegWrite;
  logic [4:0]  WBRDaddr;
  logic [31:0] WBdata;
  logic        MemRead_o, MemtoReg_o;
  logic        MemWrite_o, RegWrite_o;
  logic [31:0] ALUresult_o, RS2data_o;
  logic [4:0]  RDaddr_o;
  logic        stall_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk_i(clk), .rst_i(rst),
    .mem_stall_i(mem_stall),
    .MemRead_i(MemRead), .MemtoReg_i(MemtoReg),
    .MemWrite_i(MemWrite), .ALUSrc_i(ALUSrc),
    .RegWrite_i(RegWrite), .ALUOp_i(ALUOp),
    .funct_i(funct), .RS1data_i(RS1data),
    .RS2data_i(RS2data), .imm_i(imm),
    .RDaddr_i(RDaddr), .RS1addr_i(RS1addr),
    .RS2addr_i(RS2addr),
    .WBRegWrite_i(WBRegWrite),
    .WBRDaddr_i(WBRDaddr), .WBdata_i(WBdata),
    .MemRead_o(MemRead_o), .MemtoReg_o(MemtoReg_o),
    .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o),
    .ALUresult_o(ALUresult_o),
    .RS2data_o(RS2data_o), .RDaddr_o(RDaddr_o),
    .stall_o(stall_o)
  );

  typedef struct packed {
    logic        mr, mtr, mw, rw;
    logic [31:0] alu, rs2;
    logic [4:0]  rd;
  } exm_t;

  typedef struct packed {
    logic        mr, mtr, mw, alusrc, rw;
    logic [1:0]  op;
    logic [9:0]  funct;
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  rd, rs1, rs2;
    logic        wbrw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
  } ins_t;

  exm_t exp_q[$];
  exm_t model_exm;
  int   checks = 0;
  int   errors = 0;

  task automatic chk32(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic chke(input string nm,
                      input exm_t act,
                      input exm_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic exm_t cur_out();
    return {MemRead_o, MemtoReg_o, MemWrite_o,
            RegWrite_o, ALUresult_o, RS2data_o,
            RDaddr_o};
  endfunction

  // Reference ALU straight from the instruction semantics.
  function automatic logic [31:0] ref_alu(
      input logic [1:0] op, input logic [9:0] f,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] im);
    logic [31:0] r;
    r = '0;
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: case (f)
        10'h000: r = a + b;
        10'h100: r = a - b;
        10'h007: r = a & b;
        10'h006: r = a | b;
        10'h004: r = a ^ b;
        10'h001: r = a << b[4:0];
        10'h105: r = $signed(a) >>> b[4:0];
        10'h008: r = a * b;
        default: r = '0;
      endcase
      default: case (f[2:0])
        3'd0: r = a + b;
        3'd5: r = $signed(a) >>> im[4:0];
        default: r = '0;
      endcase
    endcase
    return r;
  endfunction

  function automatic logic [31:0] fwd(
      input logic [4:0] a, input logic [31:0] d,
      input ins_t i);
    if (model_exm.rw && model_exm.rd != 0
        && model_exm.rd == a)
      return model_exm.alu;
    if (i.wbrw && i.wbrd != 0 && i.wbrd == a)
      return i.wbd;
    return d;
  endfunction

  function automatic exm_t predict(input ins_t i);
    logic [31:0] a, s, b;
    a = fwd(i.rs1, i.rs1d, i);
    s = fwd(i.rs2, i.rs2d, i);
    b = i.alusrc ? i.imm : s;
    return {i.mr, i.mtr, i.mw, i.rw,
            ref_alu(i.op, i.funct, a, b, i.imm),
            s, i.rd};
  endfunction

  task automatic drive(input ins_t i);
    MemRead = i.mr; MemtoReg = i.mtr;
    MemWrite = i.mw; ALUSrc = i.alusrc;
    RegWrite = i.rw; ALUOp = i.op;
    funct = i.funct; RS1data = i.rs1d;
    RS2data = i.rs2d; imm = i.imm;
    RDaddr = i.rd; RS1addr = i.rs1;
    RS2addr = i.rs2; WBRegWrite = i.wbrw;
    WBRDaddr = i.wbrd; WBdata = i.wbd;
  endtask

  task automatic idle_in();
    ins_t z;
    z = '0;
    drive(z);
    mem_stall = 1'b0;
  endtask

  // Called just after a falling edge; holds the instruction until
  // an edge with neither a memory stall nor a stage stall.
  task automatic issue(input ins_t i,
                       input int st_lo, input int st_hi,
                       input int pct,
                       output int edges, output int stalls);
    exm_t e;
    logic cons;
    drive(i);
    e = predict(i);
    exp_q.push_back(e);
    model_exm = e;
    edges = 0;
    stalls = 0;
    while (1) begin
      if (edges >= st_lo && edges <= st_hi)
        mem_stall = 1'b1;
      else
        mem_stall = ($urandom_range(99) < pct);
      #1;
      cons = !mem_stall && !stall_o;
      if (stall_o) stalls++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (cons) break;
      if (edges > 300) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: got %0d edges required <=300",
                 edges);
        break;
      end
    end
    idle_in();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    model_exm = '0;
  endtask

  function automatic ins_t mk(
      input logic [1:0] op, input logic [9:0] f,
      input logic [4:0] rd, input logic [4:0] r1,
      input logic [31:0] d1, input logic [4:0] r2,
      input logic [31:0] d2);
    ins_t i;
    i = '0;
    i.op = op; i.funct = f; i.rd = rd;
    i.rs1 = r1; i.rs1d = d1;
    i.rs2 = r2; i.rs2d = d2;
    i.rw = 1'b1;
    return i;
  endfunction

  function automatic logic [9:0] pick_f(input int k);
    case (k)
      0: return 10'h000;
      1: return 10'h100;
      2: return 10'h007;
      3: return 10'h006;
      4: return 10'h004;
      5: return 10'h001;
      6: return 10'h105;
      7: return 10'h008;
      default: return 10'($urandom);
    endcase
  endfunction

  // Monitor: every edge either resets, holds, loads a bubble or
  // retires the oldest expected result.
  logic r_s, upd_s;
  exm_t prev_s, got_s;
  always @(posedge clk) begin
    r_s = rst;
    upd_s = !mem_stall;
    prev_s = cur_out();
    #1;
    got_s = cur_out();
    if (r_s)
      chke("reset_out", got_s, '0);
    else if (!upd_s)
      chke("hold", got_s, prev_s);
    else if (RegWrite_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h required none",
                 got_s);
      end else
        chke("result", got_s, exp_q.pop_front());
    end else
      chke("bubble", got_s, '0);
  end

  ins_t ia, ib;
  int   ed, st;

  initial begin
    rst = 1'b1;
    idle_in();
    ia = mk(2'd2, 10'h008, 5'd4, 5'd1, 32'd6, 5'd2, 32'd7);
    drive(ia);
    #1;
    chk32("stall_in_reset", 32'(stall_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chke("reset_state", cur_out(), '0);
    rst = 1'b0;
    idle_in();
    model_exm = '0;

    ia = mk(2'd2, 10'h000, 5'd3, 5'd4, 32'd5, 5'd5, 32'd7);
    issue(ia, -1, -2, 0, ed, st);
    chk32("add_result", ALUresult_o, 32'd12);
    chk32("add_rd", 32'(RDaddr_o), 32'd3);
    chk32("add_rw", 32'(RegWrite_o), 32'd1);
    chk32("add_latency", 32'(ed), 32'd1);

    ia = mk(2'd0, 10'h000, 5'd1, 5'd6, 32'd2, 5'd7, 32'd3);
    issue(ia, -1, -2, 0, ed, st);
    ib = mk(2'd1, 10'h000, 5'd2, 5'd1, 32'd0, 5'd9, 32'd0);
    ib.alusrc = 1'b1;
    ib.imm = 32'd1;
    issue(ib, -1, -2, 0, ed, st);
    chk32("fwd_exmem", ALUresult_o, 32'd4);
    issue(ia, -1, -2, 0, ed, st);
    ib.wbrw = 1'b1;
    ib.wbrd = 5'd1;
    ib.wbd = 32'd9;
    issue(ib, -1, -2, 0, ed, st);
    chk32("fwd_exmem_prio", ALUresult_o, 32'd4);
    tick(1);
    issue(ib, -1, -2, 0, ed, st);
    chk32("fwd_wb", ALUresult_o, 32'd8);

    ia = mk(2'd0, 10'h000, 5'd0, 5'd6, 32'd10, 5'd7, 32'd20);
    issue(ia, -1, -2, 0, ed, st);
    ib = mk(2'd0, 10'h000, 5'd8, 5'd0, 32'd0, 5'd7, 32'd5);
    issue(ib, -1, -2, 0, ed, st);
    chk32("fwd_x0", ALUresult_o, 32'd5);

    ia = mk(2'd2, 10'h008, 5'd9, 5'd10, 32'hFFFF_FFFF,
            5'd11, 32'd3);
    issue(ia, -1, -2, 0, ed, st);
    chk32("mul_stalls", 32'(st), 32'd33);
    chk32("mul_edges", 32'(ed), 32'd34);
    chk32("mul_result", ALUresult_o, 32'hFFFF_FFFD);
    chk32("mul_rw", 32'(RegWrite_o), 32'd1);

    ia = mk(2'd2, 10'h008, 5'd12, 5'd13, 32'd6, 5'd14, 32'd7);
    issue(ia, 30, 35, 0, ed, st);
    chk32("mulst_edges", 32'(ed), 32'd37);
    chk32("mulst_stalls", 32'(st), 32'd33);
    chk32("mulst_result", ALUresult_o, 32'd42);

    tick(1);
    ia = mk(2'd2, 10'h008, 5'd5, 5'd13, 32'd6, 5'd14, 32'd7);
    drive(ia);
    mem_stall = 1'b0;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk32("rst_mid_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    model_exm = '0;
    chke("rst_mid_out", cur_out(), '0);
    tick(40);
    ia = mk(2'd2, 10'h008, 5'd5, 5'd1, 32'd2, 5'd2, 32'd3);
    issue(ia, -1, -2, 0, ed, st);
    chk32("post_rst_edges", 32'(ed), 32'd34);
    chk32("post_rst_mul", ALUresult_o, 32'd6);

    for (int n = 0; n < 250; n++) begin
      ia = '0;
      ia.op = 2'($urandom_range(3));
      ia.alusrc = (ia.op == 2'd3) ? 1'b1
                : (ia.op == 2'd2) ? 1'b0
                : 1'($urandom);
      ia.funct = (ia.op == 2'd2)
               ? pick_f($urandom_range(8))
               : 10'($urandom);
      ia.rd = 5'($urandom_range(7));
      ia.rs1 = 5'($urandom_range(7));
      ia.rs2 = 5'($urandom_range(7));
      ia.rs1d = $urandom;
      ia.rs2d = $urandom;
      ia.imm = $urandom;
      ia.mr = 1'($urandom);
      ia.mtr = 1'($urandom);
      ia.mw = 1'($urandom);
      ia.rw = 1'b1;
      ia.wbrw = 1'($urandom);
      ia.wbrd = 5'($urandom_range(7));
      ia.wbd = $urandom;
      issue(ia, -1, -2, 20, ed, st);
    end

    tick(2);
    chk32("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
